// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory and fills the
// IF/ID register. Immediate-format words (top bits 3'b110) take two fetches:
// the opcode word is latched and emitted together with the following word.
//
// Output handshake: the decode stage consumes instruction/immediate/pc_next
// only when valid=1. valid=0 marks a bubble, and then instruction=16'h0000
// (NOP). There is no ready signal; back-pressure comes only from stall,
// which freezes every register, so a presented instruction stays stable
// and is not repeated once stall drops.
module instruction_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic [15:0] immediate,
    output logic        valid,
    output logic [15:0] pc_next
);

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t      state;
    state_t      state_nx;
    logic [15:0] pc;
    logic [15:0] pc_nx;
    logic [15:0] op_word;
    logic [15:0] op_word_nx;
    logic [15:0] instruction_nx;
    logic [15:0] immediate_nx;
    logic        valid_nx;
    logic [15:0] pc_next_nx;
    logic        is_imm_fmt;

    assign imem_addr  = pc;
    assign is_imm_fmt = (imem_data[15:13] == 3'b110);

    // Next-state and next-output decode; branch beats stall, stall holds all.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        op_word_nx     = op_word;
        instruction_nx = instruction;
        immediate_nx   = immediate;
        valid_nx       = valid;
        pc_next_nx     = pc_next;
        if (branch_taken) begin
            // Flush: any half-fetched immediate instruction is dropped.
            pc_nx          = branch_target;
            state_nx       = FETCH_OP;
            op_word_nx     = 16'h0000;
            instruction_nx = 16'h0000;
            immediate_nx   = 16'h0000;
            valid_nx       = 1'b0;
        end else if (!stall) begin
            case (state)
                FETCH_OP: begin
                    pc_nx = pc + 16'd1;
                    if (is_imm_fmt) begin
                        op_word_nx     = imem_data;
                        state_nx       = FETCH_IMM;
                        instruction_nx = 16'h0000;
                        immediate_nx   = 16'h0000;
                        valid_nx       = 1'b0;
                    end else begin
                        instruction_nx = imem_data;
                        immediate_nx   = 16'h0000;
                        valid_nx       = 1'b1;
                        pc_next_nx     = pc + 16'd1;
                    end
                end
                FETCH_IMM: begin
                    // PC wraps naturally, so an opcode at 16'hFFFF reads 16'h0000.
                    pc_nx          = pc + 16'd1;
                    instruction_nx = op_word;
                    immediate_nx   = imem_data;
                    valid_nx       = 1'b1;
                    pc_next_nx     = pc + 16'd1;
                    state_nx       = FETCH_OP;
                end
                default: begin
                    state_nx = FETCH_OP;
                end
            endcase
        end
    end

    // State and IF/ID registers with synchronous reset taking top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_OP;
            pc          <= 16'h0000;
            op_word     <= 16'h0000;
            instruction <= 16'h0000;
            immediate   <= 16'h0000;
            valid       <= 1'b0;
            pc_next     <= 16'h0000;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            op_word     <= op_word_nx;
            instruction <= instruction_nx;
            immediate   <= immediate_nx;
            valid       <= valid_nx;
            pc_next     <= pc_next_nx;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random
// control traffic, checked cycle by cycle against a reference model.
module tb_instruction_fetch;

    localparam int W = 65;  // {imem_addr, instruction, immediate, valid, pc_next}

    // ---------------- clock / reset block ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic        valid;
    logic [15:0] pc_next;

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    instruction_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .immediate    (immediate),
        .valid        (valid),
        .pc_next      (pc_next)
    );

    // ---------------- reference model ----------------
    // Architectural view: a PC, an optional pending opcode that still
    // needs its immediate word, and the last emitted IF/ID contents.
    logic [15:0] m_pc = 16'h0000;
    logic        m_pending = 1'b0;
    logic [15:0] m_word = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_imm = 16'h0000;
    logic        m_valid = 1'b0;
    logic [15:0] m_pc_next = 16'h0000;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic model_step(input logic r, input logic s, input logic b,
                              input logic [15:0] t);
        logic [15:0] word;
        word = mem[m_pc];
        if (r) begin
            m_pc = 0; m_pending = 0; m_word = 0;
            m_instr = 0; m_imm = 0; m_valid = 0; m_pc_next = 0;
        end else if (b) begin
            m_pc = t; m_pending = 0;
            m_instr = 0; m_imm = 0; m_valid = 0;
        end else if (s) begin
            // everything frozen
        end else if (m_pending) begin
            m_instr = m_word; m_imm = word; m_valid = 1;
            m_pc = m_pc + 16'd1; m_pc_next = m_pc; m_pending = 0;
        end else if (word[15:13] == 3'b110) begin
            m_word = word; m_pending = 1;
            m_instr = 0; m_imm = 0; m_valid = 0;
            m_pc = m_pc + 16'd1;
        end else begin
            m_instr = word; m_imm = 0; m_valid = 1;
            m_pc = m_pc + 16'd1; m_pc_next = m_pc;
        end
        exp_q.push_back({m_pc, m_instr, m_imm, m_valid, m_pc_next});
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic s, input logic b,
                       input logic [15:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        model_step(r, s, b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {imem_addr, instruction, immediate, valid, pc_next};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_obs t=%0t got addr=%h instr=%h imm=%h valid=%b pc_next=%h expected addr=%h instr=%h imm=%h valid=%b pc_next=%h",
                         $time, a[64:49], a[48:33], a[32:17], a[16], a[15:0],
                         e[64:49], e[48:33], e[32:17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1940; mem[1] = 16'h2A00; mem[2] = 16'h0800; mem[3] = 16'h0001;
        mem[4] = 16'hC200; mem[5] = 16'h00FF;
        mem[6] = 16'h0100; mem[7] = 16'h0200; mem[8] = 16'h0300;
        mem[9] = 16'hC111; mem[10] = 16'h0BAD;
        mem[16'h40] = 16'h0440; mem[16'h41] = 16'h0441; mem[16'h42] = 16'hC0AA;
        mem[16'h80] = 16'h0880; mem[16'h50] = 16'hC055;

        // reset, then sequential fetch of 0..3 and immediate pair at 4/5
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        run(6);
        // stall for three cycles mid-stream, then resume
        run(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        run(2);
        // branch while in FETCH_IMM (opcode at 9 latched, never emitted)
        run(1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0040);
        run(3);
        // branch with stall while in FETCH_IMM: branch wins
        cyc(1'b0, 1'b1, 1'b1, 16'h0080);
        run(1);
        // reset with branch: reset wins
        cyc(1'b1, 1'b0, 1'b1, 16'h1234);
        run(1);
        // reset in FETCH_IMM abandons the partial fetch
        cyc(1'b0, 1'b0, 1'b1, 16'h0050);
        run(1);
        cyc(1'b1, 1'b1, 1'b1, 16'h0099);
        run(2);
        // wrap-around: opcode at FFFF takes its immediate from 0000
        mem[16'hFFFF] = 16'hC000; mem[0] = 16'h1234; mem[1] = 16'h2A00;
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF);
        run(3);

        // random control traffic over random memory
        for (int i = 0; i < 2000; i++) begin
            logic r, s, b;
            logic [15:0] t;
            r = ($urandom_range(0, 63) == 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                            : 16'($urandom);
            cyc(r, s, b, t);
        end

        rst = 1'b0; stall = 1'b1; branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-003 SHALL have ports: stall  input  1  hold all state and outputs this cycle.
REQ-004 SHALL have ports: branch_taken  input  1  redirect the PC and flush the in-flight fetch.
REQ-005 SHALL have ports: branch_target  input  16  new PC when branch_taken=1.
REQ-006 SHALL have ports: imem_addr  output  16  word address to instruction memory; equals PC combinationally.
REQ-007 SHALL have ports: imem_data  input  16  instruction memory read data for imem_addr, valid in the same cycle.
REQ-008 SHALL have ports: instruction  output  16  IF/ID register; feeds the decode stage.
REQ-009 SHALL have ports: immediate  output  16  IF/ID immediate word; 0 for non-immediate instructions.
REQ-010 SHALL have ports: valid  output  1  1 when instruction/immediate hold a real instruction; 0 means bubble.
REQ-011 SHALL have ports: pc_next  output  16  address following the last word of the registered instruction.

Function
REQ-012 SHALL maintain a 16-bit PC; memory is word-addressed, so the increment is +1.
REQ-013 SHALL treat a word as immediate-format when imem_data[15:13]=3'b110; any other word is single-word.
REQ-014 SHALL implement FSM states FETCH_OP and FETCH_IMM; the reset state is FETCH_OP.
REQ-015 SHALL apply priority per edge: rst > branch_taken > stall > normal operation.
REQ-016 SHALL, in FETCH_OP with a single-word instruction: instruction<=imem_data, immediate<=0, valid<=1, pc_next<=PC+1, PC<=PC+1, remain in FETCH_OP.
REQ-017 SHALL, in FETCH_OP with an immediate-format word: latch the word internally, PC<=PC+1, go to FETCH_IMM, instruction<=0, immediate<=0, valid<=0 (bubble).
REQ-018 SHALL, in FETCH_IMM: instruction<=latched word, immediate<=imem_data, valid<=1, pc_next<=PC+1, PC<=PC+1, go to FETCH_OP.
REQ-019 SHALL, on branch_taken=1 in either state: PC<=branch_target, state<=FETCH_OP, instruction<=0, immediate<=0, valid<=0, discard the latched word; pc_next holds its value.
REQ-020 SHALL, on stall=1 with branch_taken=0: hold PC, FSM state, latched word and all registered outputs unchanged.
REQ-021 SHALL wrap the PC modulo 2^16 (16'hFFFF+1 = 16'h0000); an immediate-format word at 16'hFFFF takes its immediate from 16'h0000.
REQ-022 SHALL have a latency of one cycle from a word's address on imem_addr to its appearance on instruction for single-word instructions, and two cycles for immediate-format instructions.
REQ-023 SHALL drive instruction=16'h0000 on every bubble; decode treats 16'h0000 as NOP.

Reset
REQ-024 SHALL, when rst=1 at a rising edge: PC<=0, state<=FETCH_OP, latched word<=0, instruction<=0, immediate<=0, valid<=0, pc_next<=0, regardless of stall or branch_taken.
REQ-025 SHALL, on reset asserted in FETCH_IMM, abandon the partial fetch; the first fetch after reset is from address 0.
REQ-026 SHALL NOT change any state on a clock edge where rst=0, stall=1 and branch_taken=0.

Verification
REQ-027 Sequential fetch: rst for 1 cycle, memory[0..2]=16'h1940,16'h2A00,16'h0800 -> imem_addr 0,1,2,3 on successive cycles; instruction 16'h1940,16'h2A00,16'h0800 with valid=1; pc_next 1,2,3.
REQ-028 Immediate fetch: memory[4]=16'hC200, memory[5]=16'h00FF, PC=4 -> one bubble cycle (valid=0, instruction=0), then instruction=16'hC200, immediate=16'h00FF, valid=1, pc_next=6.
REQ-029 Stall: assert stall for 3 cycles mid-stream -> imem_addr, instruction, immediate, valid and pc_next are frozen for all 3 cycles; the stream resumes without loss or duplication.
REQ-030 Branch during FETCH_IMM: branch_taken=1, branch_target=16'h0040 while in FETCH_IMM -> next cycle imem_addr=16'h0040, valid=0, instruction=0; the latched word is never emitted.
REQ-031 Branch+stall+reset priority: branch_taken=1 with stall=1 -> branch wins (PC=target); rst=1 with branch_taken=1 -> PC=0 and valid=0.
REQ-032 Wrap-around: branch to 16'hFFFF with memory[16'hFFFF]=16'hC000 and memory[0]=16'h1234 -> imem_addr wraps to 16'h0000; instruction=16'hC000, immediate=16'h1234, pc_next=16'h0001.
